// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path: segment bit order,
// the hex-to-segment code table and the all-dark code.
package seg_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

    // Entry n is the lit-segment pattern for hex digit n (entry 0 is rightmost).
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E, 7'h1F, 7'h77, 7'h7B, 7'h7F,
        7'h70, 7'h5F, 7'h5B, 7'h33, 7'h79, 7'h6D, 7'h30, 7'h7E
    };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex nibble to seven-segment pattern (1 = lit, a..g in bits 6..0).
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment driver with a pending/display double buffer
// so that a new value only ever takes effect on a whole-frame boundary.
module seg_mux_driver
    import seg_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int PRESCALE   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    output logic                  ready,
    output logic [SEG_W-1:0]      seg_out,
    output logic [DIGITS-1:0]     dig_en
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int VW = 4 * DIGITS;

    logic [PW-1:0]     presc_q, presc_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [VW-1:0]     disp_val_q, disp_val_d;
    logic [DIGITS-1:0] disp_blank_q, disp_blank_d;
    logic              disp_lz_q, disp_lz_d;
    logic [VW-1:0]     pend_val_q, pend_val_d;
    logic [DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic              pend_lz_q, pend_lz_d;
    logic              pend_valid_q, pend_valid_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;

    logic              tick;
    logic              frame_end;
    logic              accept;
    logic              upper_zero;
    logic [DIGITS-1:0] dark_vec;
    logic [3:0]        cur_nib;
    logic              cur_dark;
    logic [SEG_W-1:0]  dec_seg;

    assign ready  = !pend_valid_q;
    assign accept = load && ready;

    always_comb begin
        tick      = (presc_q == PW'(PRESCALE - 1));
        frame_end = tick && (idx_q == IW'(DIGITS - 1));

        presc_d = tick ? '0 : presc_q + PW'(1);
        idx_d   = idx_q;
        if (tick) begin
            idx_d = frame_end ? '0 : idx_q + IW'(1);
        end

        disp_val_d   = disp_val_q;
        disp_blank_d = disp_blank_q;
        disp_lz_d    = disp_lz_q;
        pend_val_d   = pend_val_q;
        pend_blank_d = pend_blank_q;
        pend_lz_d    = pend_lz_q;
        pend_valid_d = pend_valid_q;

        // A load can only be accepted while nothing is pending, so commit and
        // capture are never both active; a boundary-cycle load waits a frame.
        if (frame_end && pend_valid_q) begin
            disp_val_d   = pend_val_q;
            disp_blank_d = pend_blank_q;
            disp_lz_d    = pend_lz_q;
            pend_valid_d = 1'b0;
        end
        if (accept) begin
            pend_val_d   = value;
            pend_blank_d = blank_mask;
            pend_lz_d    = lz_en;
            pend_valid_d = 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is a leading zero
    // while every nibble from it upward is zero. Digit 0 always shows.
    always_comb begin
        upper_zero = 1'b1;
        dark_vec   = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            upper_zero  = upper_zero && (disp_val_q[4*i +: 4] == 4'h0);
            dark_vec[i] = disp_blank_q[i] || (disp_lz_q && (i != 0) && upper_zero);
        end
    end

    always_comb begin
        cur_nib  = disp_val_q[3:0];
        cur_dark = dark_vec[0];
        dig_d    = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig_d[i] = (idx_q == IW'(i));
            if (idx_q == IW'(i)) begin
                cur_nib  = disp_val_q[4*i +: 4];
                cur_dark = dark_vec[i];
            end
        end
        seg_d = cur_dark ? SEG_OFF : dec_seg;
    end

    seg_hex_decoder u_dec (
        .nibble (cur_nib),
        .seg    (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            disp_val_q   <= '0;
            disp_blank_q <= '0;
            disp_lz_q    <= 1'b0;
            pend_val_q   <= '0;
            pend_blank_q <= '0;
            pend_lz_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dig_q        <= '0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            disp_val_q   <= disp_val_d;
            disp_blank_q <= disp_blank_d;
            disp_lz_q    <= disp_lz_d;
            pend_val_q   <= pend_val_d;
            pend_blank_q <= pend_blank_d;
            pend_lz_q    <= pend_lz_d;
            pend_valid_q <= pend_valid_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
        end
    end

    assign seg_out = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
    assign dig_en  = (ACTIVE_LOW != 0) ? ~dig_q : dig_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// Scoreboard bench for seg_mux_driver (DIGITS=4, PRESCALE=4); an active-high
// and an active-low instance run in lockstep from the same stimulus.
module tb_seg_mux_driver;

    typedef logic [3:0][6:0] frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blank_mask = '0;
    logic        lz_en = 1'b0;

    logic        ready, ready_al;
    logic [6:0]  seg_out, seg_out_al;
    logic [3:0]  dig_en, dig_en_al;

    int checks = 0;
    int errors = 0;
    frame_t sb_q[$];

    seg_mux_driver #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .ready      (ready),
        .seg_out    (seg_out),
        .dig_en     (dig_en)
    );

    seg_mux_driver #(.DIGITS(4), .PRESCALE(4), .ACTIVE_LOW(1)) dut_al (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .ready      (ready_al),
        .seg_out    (seg_out_al),
        .dig_en     (dig_en_al)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hex_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    function automatic frame_t exp_frame(input logic [15:0] v, input logic [3:0] m, input logic lz);
        frame_t f;
        logic dark, all0;
        for (int i = 0; i < 4; i++) begin
            dark = m[i];
            if (lz && i != 0) begin
                all0 = 1'b1;
                for (int j = i; j < 4; j++) if (v[4*j +: 4] != 4'h0) all0 = 1'b0;
                if (all0) dark = 1'b1;
            end
            f[i] = dark ? 7'h00 : hex_code(v[4*i +: 4]);
        end
        return f;
    endfunction

    // Compares 16 consecutive cycles, starting with the current one, against
    // the oldest expected frame on the scoreboard.
    task automatic check_frame(input string tag);
        frame_t f;
        logic [3:0] d;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL %s: scoreboard empty, nothing to compare", tag);
        end else begin
            f = sb_q.pop_front();
            for (int s = 0; s < 4; s++) begin
                for (int c = 0; c < 4; c++) begin
                    if (s != 0 || c != 0) @(negedge clk);
                    d = 4'(1 << s);
                    checks += 4;
                    if (seg_out !== f[s]) begin
                        errors++;
                        $display("[TB] FAIL %s seg slot%0d cyc%0d: got %h expected %h", tag, s, c, seg_out, f[s]);
                    end
                    if (dig_en !== d) begin
                        errors++;
                        $display("[TB] FAIL %s dig slot%0d cyc%0d: got %b expected %b", tag, s, c, dig_en, d);
                    end
                    if (seg_out_al !== ~f[s]) begin
                        errors++;
                        $display("[TB] FAIL %s seg_al slot%0d cyc%0d: got %h expected %h", tag, s, c, seg_out_al, ~f[s]);
                    end
                    if (dig_en_al !== ~d) begin
                        errors++;
                        $display("[TB] FAIL %s dig_al slot%0d cyc%0d: got %b expected %b", tag, s, c, dig_en_al, ~d);
                    end
                end
            end
        end
    endtask

    task automatic wait_frame_start(input string tag);
        logic [3:0] prev;
        bit found;
        int n;
        prev = dig_en;
        found = 1'b0;
        n = 0;
        while (!found && n < 64) begin
            @(negedge clk);
            n++;
            if (prev == 4'b1000 && dig_en == 4'b0001) found = 1'b1;
            else prev = dig_en;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL %s frame_start: got timeout after %0d cycles expected a 1000->0001 wrap", tag, n);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s ready_wait: got ready=%b after %0d cycles expected 1", tag, ready, n);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic lz);
        wait_ready("do_load");
        value      = v;
        blank_mask = m;
        lz_en      = lz;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (seg_out !== 7'h00)    begin errors++; $display("[TB] FAIL rst seg: got %h expected 00", seg_out); end
        if (dig_en !== 4'h0)      begin errors++; $display("[TB] FAIL rst dig: got %b expected 0000", dig_en); end
        if (seg_out_al !== 7'h7F) begin errors++; $display("[TB] FAIL rst seg_al: got %h expected 7f", seg_out_al); end
        if (dig_en_al !== 4'hF)   begin errors++; $display("[TB] FAIL rst dig_al: got %b expected 1111", dig_en_al); end
        if (ready !== 1'b1)       begin errors++; $display("[TB] FAIL rst ready: got %b expected 1", ready); end
        rst_n = 1'b1;
        sb_q.push_back(exp_frame(16'h0000, 4'b0000, 1'b0));
        @(negedge clk);
        check_frame("reset_frame");
    endtask

    task automatic test_basic_load();
        sb_q.push_back(exp_frame(16'h1234, 4'b0000, 1'b0));
        do_load(16'h1234, 4'b0000, 1'b0);
        wait_ready("basic");
        wait_frame_start("basic");
        check_frame("basic_1234");
    endtask

    task automatic test_leading_zero();
        sb_q.push_back(exp_frame(16'h0070, 4'b0000, 1'b1));
        do_load(16'h0070, 4'b0000, 1'b1);
        wait_ready("lz_on");
        wait_frame_start("lz_on");
        check_frame("lz_on_0070");
        sb_q.push_back(exp_frame(16'h0070, 4'b0000, 1'b0));
        do_load(16'h0070, 4'b0000, 1'b0);
        wait_ready("lz_off");
        wait_frame_start("lz_off");
        check_frame("lz_off_0070");
    endtask

    task automatic test_back_to_back();
        sb_q.push_back(exp_frame(16'h5A3C, 4'b0000, 1'b0));
        sb_q.push_back(exp_frame(16'h5A3C, 4'b0000, 1'b0));
        do_load(16'h5A3C, 4'b0000, 1'b0);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL b2b ready_low: got %b expected 0", ready); end
        value = 16'hFFFF;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        wait_ready("b2b");
        wait_frame_start("b2b_1");
        check_frame("b2b_first");
        wait_frame_start("b2b_2");
        check_frame("b2b_second");
    endtask

    task automatic test_boundary_load();
        frame_t old_f;
        int n;
        old_f = exp_frame(16'h5A3C, 4'b0000, 1'b0);
        wait_frame_start("bnd");
        repeat (14) @(negedge clk);
        checks++;
        if (dig_en !== 4'b1000) begin errors++; $display("[TB] FAIL bnd align: got %b expected 1000", dig_en); end
        sb_q.push_back(exp_frame(16'h9B0E, 4'b0000, 1'b0));
        do_load(16'h9B0E, 4'b0000, 1'b0);
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL bnd ready_low: got %b expected 0", ready); end
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                checks++;
                if (seg_out !== old_f[0]) begin
                    errors++;
                    $display("[TB] FAIL bnd old_digit0: got %h expected %h", seg_out, old_f[0]);
                end
            end
        end
        checks++;
        if (n != 16) begin errors++; $display("[TB] FAIL bnd ready_delay: got %0d cycles expected 16", n); end
        wait_frame_start("bnd_new");
        check_frame("bnd_9b0e");
    endtask

    task automatic test_blank();
        sb_q.push_back(exp_frame(16'h8888, 4'b0101, 1'b0));
        do_load(16'h8888, 4'b0101, 1'b0);
        wait_ready("blank");
        wait_frame_start("blank");
        check_frame("blank_8888");
    endtask

    task automatic test_reset_pending();
        do_load(16'hABCD, 4'b0000, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 5;
        if (seg_out !== 7'h00)    begin errors++; $display("[TB] FAIL rstp seg: got %h expected 00", seg_out); end
        if (dig_en !== 4'h0)      begin errors++; $display("[TB] FAIL rstp dig: got %b expected 0000", dig_en); end
        if (seg_out_al !== 7'h7F) begin errors++; $display("[TB] FAIL rstp seg_al: got %h expected 7f", seg_out_al); end
        if (dig_en_al !== 4'hF)   begin errors++; $display("[TB] FAIL rstp dig_al: got %b expected 1111", dig_en_al); end
        if (ready !== 1'b1)       begin errors++; $display("[TB] FAIL rstp ready: got %b expected 1", ready); end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(exp_frame(16'h0000, 4'b0000, 1'b0));
        sb_q.push_back(exp_frame(16'h0000, 4'b0000, 1'b0));
        @(negedge clk);
        check_frame("rstp_frame0");
        wait_frame_start("rstp");
        check_frame("rstp_frame1");
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got simulation timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_load();
        test_leading_zero();
        test_back_to_back();
        test_boundary_load();
        test_blank();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_mux_driver.md
SEG_MUX_DRIVER -- requirements
Module: seg_mux_driver

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL have parameter PRESCALE, default 1000, meaning clk cycles per digit slot (legal values ≥2).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 0, meaning that when 1, seg_out and dig_en are inverted at the pins.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 load  in  1  request to accept a new display value.
REQ-007 value  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, and digit 0 is the least significant digit.
REQ-008 blank_mask  in  DIGITS  bit i=1 forces digit i dark; sampled together with value.
REQ-009 lz_en  in  1  leading-zero suppression enable; sampled together with value.
REQ-010 ready  out  1  high when a load will be accepted.
REQ-011 seg_out  out  7  segments, bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g; 1=lit before polarity.
REQ-012 dig_en  out  DIGITS  one-hot digit select; 1=enabled before polarity.

Function
REQ-013 The prescaler SHALL count 0..PRESCALE-1 and wrap; tick is asserted when count==PRESCALE-1.
REQ-014 On tick, the digit index SHALL advance modulo DIGITS; the wrap from DIGITS-1 to 0 is the frame boundary.
REQ-015 A load SHALL be accepted only when load&&ready; on acceptance, value, blank_mask and lz_en SHALL be captured into a pending buffer, and ready SHALL go low the next cycle.
REQ-016 load while ready is low SHALL be ignored with no effect on any state.
REQ-017 At a frame boundary with pending valid, the pending buffer SHALL be copied into the display register, and ready SHALL return high the next cycle; a frame SHALL never show a mix of old and new values.
REQ-018 If load is accepted in the same cycle as a frame boundary, the data SHALL stay pending until the next boundary.
REQ-019 Decode SHALL follow hex 0..F = 7E,30,6D,79,33,5B,5F,70,7F,7B,77,1F,4E,3D,4F,47.
REQ-020 A digit i is dark (segments 00) if blank_mask[i]=1, or if lz_en=1, i≠0, and all nibbles i..DIGITS-1 are zero; digit 0 is never suppressed by lz_en.
REQ-021 dig_en SHALL be one-hot at the current index even for a dark digit.
REQ-022 seg_out and dig_en SHALL be registered, so they reflect the index and display register with 1-cycle latency.
REQ-023 With ACTIVE_LOW=1, both outputs SHALL be bitwise inverted after the registers; there SHALL be no other behavioural difference.
REQ-024 With DIGITS=1, every tick is a frame boundary, and dig_en SHALL be constant 1 after reset.

Reset
REQ-025 While rst_n=0, all of the following SHALL be 0: prescaler, index, display register, pending buffer and pending flag.
REQ-026 While rst_n=0, ready SHALL be 1, and seg_out and dig_en SHALL be inactive (all segments and digits off at the pins).
REQ-027 In the first cycle after rst_n rises, the registers SHALL load digit 0 of value 0, giving seg_out=7E and dig_en=...0001 (pre-polarity).
REQ-028 Reset mid-frame or with a load pending SHALL discard the pending data; nothing SHALL be committed.

Structure
REQ-029 Shared package seg_pkg SHALL hold the 16-entry segment code table, the segment bit-order constants and the SEG_OFF constant.
REQ-030 A combinational sub-module seg_hex_decoder (4-bit in, 7-bit out, using seg_pkg) SHALL be instantiated once on the muxed nibble.

Verification
REQ-031 Scenario (DIGITS=4, PRESCALE=4): reset, then load value=0x1234 -> after the next frame boundary, the slots show digit0 7E..., and the next frame shows digits 0..3 = 33,79,6D,30 with dig_en 0001,0010,0100,1000, each held for 4 cycles.
REQ-032 Scenario: load 0x0070 with lz_en=1 -> digits 3 and 2 dark, digit1=70, digit0=7E; the same value with lz_en=0 gives digits 3 and 2 = 7E.
REQ-033 Scenario: with one load pending, a second load of 0xFFFF while ready=0 -> ignored; display changes only to the first value.
REQ-034 Scenario: load asserted exactly on a frame-boundary cycle -> ready low, commit at the following boundary, ready high 1 cycle later.
REQ-035 Scenario: blank_mask=0101 with value 0x8888 -> digits 0 and 2 at 00, digits 1 and 3 at 7F; with ACTIVE_LOW=1, the pins show 7F/00 inverted and dig_en active-low.
REQ-036 Scenario: rst_n pulsed low mid-slot while a load is pending -> outputs go inactive asynchronously, and after release seg_out=7E on digit 0.
